// File: rtl/pulse_tx_if.sv
// pulse_tx_if: request handshake and pin-side status bundle for pulse_tx.
`default_nettype none

interface pulse_tx_if;
  logic req_valid;
  logic req_ready;
  logic out;
  logic busy;

  modport master (
    output req_valid,
    input  req_ready,
    input  out,
    input  busy
  );

  modport slave (
    input  req_valid,
    output req_ready,
    output out,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/pulse_tx.sv
// ============================================================================
// pulse_tx: turns single-cycle requests into pulses with guaranteed minimum
// high time and low gap, buffering requests in a small pending counter.
// Optional macro PULSE_TX_COUNT_EN adds the 16-bit sent_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_tx #(
  parameter int PULSE_HIGH  = 8,
  parameter int PULSE_LOW   = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  pulse_tx_if.slave bus
`ifdef PULSE_TX_COUNT_EN
  ,
  output logic [15:0] sent_count
`endif
);

  if (PULSE_HIGH < 1) begin : g_bad_pulse_high
    $fatal(1, "pulse_tx: PULSE_HIGH must be at least 1");
  end
  if (PULSE_LOW < 1) begin : g_bad_pulse_low
    $fatal(1, "pulse_tx: PULSE_LOW must be at least 1");
  end
  if (QUEUE_DEPTH < 1) begin : g_bad_queue_depth
    $fatal(1, "pulse_tx: QUEUE_DEPTH must be at least 1");
  end

  localparam int c_PEND_W = $clog2(QUEUE_DEPTH + 1);
  localparam int c_TMAX   = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int c_TW     = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

  localparam logic [c_PEND_W-1:0] c_QD       = c_PEND_W'(QUEUE_DEPTH);
  localparam logic [c_PEND_W-1:0] c_PEND_ONE = c_PEND_W'(1);
  localparam logic [c_PEND_W-1:0] c_PEND_NIL = '0;
  localparam logic [c_TW-1:0]     c_HI_LOAD  = c_TW'(PULSE_HIGH - 1);
  localparam logic [c_TW-1:0]     c_LO_LOAD  = c_TW'(PULSE_LOW - 1);
  localparam logic [c_TW-1:0]     c_T_ONE    = c_TW'(1);
  localparam logic [c_TW-1:0]     c_T_NIL    = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_PEND_W-1:0] r_pending;
  logic [c_PEND_W-1:0] w_pending_next;
  logic [c_TW-1:0]     r_timer;
  logic [c_TW-1:0]     w_timer_next;
  logic                r_out;
  logic                w_ready;
  logic                w_accept;
  logic                w_pop;

  assign w_ready  = (r_pending < c_QD);
  assign w_accept = bus.req_valid && w_ready;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    // Timer parks at zero rather than wrapping while a state waits.
    w_timer_next = (r_timer != c_T_NIL) ? (r_timer - c_T_ONE) : r_timer;
    case (r_state)
      S_IDLE: begin
        if (r_pending != c_PEND_NIL) begin
          w_next_state = S_HIGH;
          w_pop        = 1'b1;
          w_timer_next = c_HI_LOAD;
        end
      end
      S_HIGH: begin
        if (r_timer == c_T_NIL) begin
          w_next_state = S_GAP;
          w_timer_next = c_LO_LOAD;
        end
      end
      S_GAP: begin
        if (r_timer == c_T_NIL) begin
          if (r_pending != c_PEND_NIL) begin
            w_next_state = S_HIGH;
            w_pop        = 1'b1;
            w_timer_next = c_HI_LOAD;
          end else begin
            w_next_state = S_IDLE;
            w_timer_next = c_T_NIL;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_timer_next = c_T_NIL;
      end
    endcase
  end

  always_comb begin
    w_pending_next = r_pending;
    if (w_accept && !w_pop) begin
      w_pending_next = r_pending + c_PEND_ONE;
    end else if (!w_accept && w_pop) begin
      w_pending_next = r_pending - c_PEND_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= c_PEND_NIL;
      r_timer   <= c_T_NIL;
      r_out     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pending_next;
      r_timer   <= w_timer_next;
      r_out     <= (w_next_state == S_HIGH);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out       = r_out;
  assign bus.busy      = (r_state != S_IDLE) || (r_pending != c_PEND_NIL);

`ifdef PULSE_TX_COUNT_EN
  logic [15:0] r_sent_count;

  // A pulse counts as sent once its high phase has fully elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent_count <= 16'd0;
    end else if ((r_state == S_HIGH) && (r_timer == c_T_NIL)) begin
      r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign sent_count = r_sent_count;
`endif

endmodule

`default_nettype wire
